// File: rtl/segment_pkg.sv
// Shared definitions for the segment transition controller: mode codes,
// controller states and the infinite-repeat marker.
package segment_pkg;

    localparam logic [7:0] TRANSITION_SYNC_IDX  = 8'h00;
    localparam logic [7:0] TRANSITION_SYS_TIME  = 8'h01;
    localparam logic [7:0] TRANSITION_GPIO      = 8'h02;
    localparam logic [7:0] TRANSITION_EXT       = 8'hF0;
    localparam logic [7:0] TRANSITION_IMMEDIATE = 8'hFF;

    // Wide enough for any REP_WIDTH up to 64; users slice the low bits.
    localparam logic [63:0] REP_INFINITE = '1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT_SYNC,
        ST_WAIT_TIME,
        ST_WAIT_GPIO
    } seg_state_t;

endpackage

// File: rtl/segment_transition_ctrl_gpio_sync.sv
// Per-bit two-flop synchroniser followed by a rising-edge detector for the
// asynchronous GPIO trigger pins.
module gpio_edge_sync #(
    parameter int unsigned NUM_GPIO = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [NUM_GPIO-1:0] GPIO_IN,
    output logic [NUM_GPIO-1:0] RISE
);

    logic [NUM_GPIO-1:0] meta_q;
    logic [NUM_GPIO-1:0] sync_q;
    logic [NUM_GPIO-1:0] prev_q;

    // Synchronise the pins and keep one older copy for edge detection.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= GPIO_IN;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign RISE = sync_q & ~prev_q;

endmodule

// File: rtl/segment_transition_ctrl.sv
// Segment transition controller: owns the active segment, sample index and
// loop counter, and applies requested segment changes when their trigger
// (immediate, index wrap, system time or GPIO edge) arrives.
module segment_transition_ctrl
    import segment_pkg::*;
#(
    parameter  int unsigned NUM_SEGMENTS = 4,
    parameter  int unsigned IDX_WIDTH    = 16,
    parameter  int unsigned REP_WIDTH    = 32,
    parameter  int unsigned NUM_GPIO     = 4,
    localparam int unsigned SEG_W        = $clog2(NUM_SEGMENTS),
    localparam int unsigned GPIO_W       = $clog2(NUM_GPIO)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 UPDATE,
    input  logic [SEG_W-1:0]     REQ_SEGMENT,
    input  logic [7:0]           TRANSITION_MODE,
    input  logic [63:0]          TRANSITION_TIME,
    input  logic [IDX_WIDTH-1:0] CYCLE [NUM_SEGMENTS],
    input  logic [REP_WIDTH-1:0] REP [NUM_SEGMENTS],
    input  logic                 STEP,
    input  logic [63:0]          SYS_TIME,
    input  logic [NUM_GPIO-1:0]  GPIO_IN,
    output logic [SEG_W-1:0]     SEGMENT,
    output logic [IDX_WIDTH-1:0] IDX,
    output logic                 STOP,
    output logic                 PENDING,
    output logic                 SWITCHED,
    output logic                 REQ_ERR
);

    localparam logic [SEG_W-1:0]     LAST_SEG = SEG_W'(NUM_SEGMENTS - 1);
    localparam logic [REP_WIDTH-1:0] REP_INF  = REP_INFINITE[REP_WIDTH-1:0];

    seg_state_t           state_q, state_d;
    logic [SEG_W-1:0]     seg_q, seg_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic [REP_WIDTH-1:0] loop_q, loop_d;
    logic                 stop_q, stop_d;
    logic                 ext_q, ext_d;
    logic                 switched_q, switched_d;
    logic                 req_err_q, req_err_d;
    logic [SEG_W-1:0]     req_seg_q, req_seg_d;
    logic [7:0]           mode_q, mode_d;
    logic [63:0]          time_q, time_d;
    logic                 time_hit_q, time_hit_d;

    logic [NUM_GPIO-1:0]  gpio_rise;
    logic [IDX_WIDTH-1:0] cycle_cur;
    logic [REP_WIDTH-1:0] rep_cur;
    logic                 at_end;
    logic                 trigger;
    logic                 accept;

    gpio_edge_sync #(
        .NUM_GPIO(NUM_GPIO)
    ) u_gpio_sync (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .GPIO_IN(GPIO_IN),
        .RISE   (gpio_rise)
    );

    assign cycle_cur = CYCLE[seg_q];
    assign rep_cur   = REP[seg_q];
    // >= so a live CYCLE reduction below the current index wraps on the next STEP.
    assign at_end    = (idx_q >= cycle_cur);

    // State and playback registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_RUN;
            seg_q      <= '0;
            idx_q      <= '0;
            loop_q     <= '0;
            stop_q     <= 1'b0;
            ext_q      <= 1'b0;
            switched_q <= 1'b0;
            req_err_q  <= 1'b0;
            req_seg_q  <= '0;
            mode_q     <= '0;
            time_q     <= '0;
            time_hit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            seg_q      <= seg_d;
            idx_q      <= idx_d;
            loop_q     <= loop_d;
            stop_q     <= stop_d;
            ext_q      <= ext_d;
            switched_q <= switched_d;
            req_err_q  <= req_err_d;
            req_seg_q  <= req_seg_d;
            mode_q     <= mode_d;
            time_q     <= time_d;
            time_hit_q <= time_hit_d;
        end
    end

    // Next state: pending trigger first, then playback, then a new request.
    // A trigger applies the old request before a same-cycle UPDATE is
    // latched; an immediate UPDATE then overrides whatever the trigger did.
    always_comb begin
        state_d    = state_q;
        seg_d      = seg_q;
        idx_d      = idx_q;
        loop_d     = loop_q;
        stop_d     = stop_q;
        ext_d      = ext_q;
        switched_d = 1'b0;
        req_err_d  = 1'b0;
        req_seg_d  = req_seg_q;
        mode_d     = mode_q;
        time_d     = time_q;
        accept     = 1'b0;

        unique case (state_q)
            ST_WAIT_SYNC: trigger = STEP && (stop_q || at_end);
            ST_WAIT_TIME: trigger = time_hit_q;
            ST_WAIT_GPIO: trigger = gpio_rise[time_q[GPIO_W-1:0]];
            default:      trigger = 1'b0;
        endcase

        if (trigger) begin
            seg_d      = req_seg_q;
            idx_d      = '0;
            loop_d     = '0;
            stop_d     = 1'b0;
            ext_d      = (mode_q == TRANSITION_EXT);
            switched_d = 1'b1;
            state_d    = ST_RUN;
        end else if (STEP && !stop_q) begin
            if (at_end) begin
                if (rep_cur != REP_INF && loop_q >= rep_cur) begin
                    if (ext_q) begin
                        seg_d      = (seg_q == LAST_SEG) ? '0 : seg_q + 1'b1;
                        idx_d      = '0;
                        loop_d     = '0;
                        switched_d = 1'b1;
                    end else begin
                        idx_d  = cycle_cur;
                        stop_d = 1'b1;
                    end
                end else begin
                    idx_d  = '0;
                    loop_d = loop_q + 1'b1;
                end
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        if (UPDATE) begin
            unique case (TRANSITION_MODE)
                TRANSITION_IMMEDIATE, TRANSITION_EXT: begin
                    accept     = 1'b1;
                    seg_d      = REQ_SEGMENT;
                    idx_d      = '0;
                    loop_d     = '0;
                    stop_d     = 1'b0;
                    ext_d      = (TRANSITION_MODE == TRANSITION_EXT);
                    switched_d = 1'b1;
                    state_d    = ST_RUN;
                end
                TRANSITION_SYNC_IDX: begin
                    accept  = 1'b1;
                    state_d = ST_WAIT_SYNC;
                end
                TRANSITION_SYS_TIME: begin
                    accept  = 1'b1;
                    state_d = ST_WAIT_TIME;
                end
                TRANSITION_GPIO: begin
                    accept  = 1'b1;
                    state_d = ST_WAIT_GPIO;
                end
                default: req_err_d = 1'b1;
            endcase
            if (accept) begin
                req_seg_d = REQ_SEGMENT;
                mode_d    = TRANSITION_MODE;
                time_d    = TRANSITION_TIME;
            end
        end

        // Cleared on a new request so a hit computed against the old
        // threshold cannot fire the replacement request.
        time_hit_d = accept ? 1'b0 : (SYS_TIME >= time_q);
    end

    assign SEGMENT  = seg_q;
    assign IDX      = idx_q;
    assign STOP     = stop_q;
    assign PENDING  = (state_q != ST_RUN);
    assign SWITCHED = switched_q;
    assign REQ_ERR  = req_err_q;

endmodule
